// File: rtl/ysyx_23060075_ifu.sv
// ysyx_23060075_ifu: single-outstanding instruction fetch unit (PC, SRAM request, decode handoff).
// Define YSYX_23060075_IFU_TIMEOUT_EN to add a 1023-cycle fetch timeout that sets err_o and halts.
module ysyx_23060075_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] raddr_o,
    output logic        rvalid_o,
    input  logic [31:0] rdata_i,
    input  logic        rready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    input  logic        pc_valid_i,
    input  logic [31:0] pc_next_i,
    output logic        err_o
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, NEXT, HALT} state_e;
    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        rvalid_q;
    logic        out_valid_q;
`ifdef YSYX_23060075_IFU_TIMEOUT_EN
    logic [9:0]  cnt_q;
    logic        err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
    assign raddr_o     = pc_q;
    assign rvalid_o    = rvalid_q;
    assign inst_o      = inst_q;
    assign inst_pc_o   = inst_pc_q;
    assign out_valid_o = out_valid_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            rvalid_q    <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef YSYX_23060075_IFU_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_q  <= REQ;
                    rvalid_q <= 1'b1;
                end
                REQ: begin
                    state_q  <= WAIT;
                    rvalid_q <= 1'b0;
`ifdef YSYX_23060075_IFU_TIMEOUT_EN
                    cnt_q    <= '0;
`endif
                end
                WAIT: begin
                    if (rready_i) begin
                        inst_q      <= rdata_i;
                        inst_pc_q   <= pc_q;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
`ifdef YSYX_23060075_IFU_TIMEOUT_EN
                    // this WAIT cycle brings the count to 1023
                    else if (cnt_q == 10'd1022) begin
                        err_q   <= 1'b1;
                        state_q <= HALT;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
`endif
                end
                HOLD: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= NEXT;
                    end
                end
                NEXT: begin
                    if (pc_valid_i) begin
                        pc_q     <= pc_next_i;
                        rvalid_q <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060075_ifu.sv
// tb_ysyx_23060075_ifu: randomized fetch loop against a transaction-level PC/memory model.
module tb_ysyx_23060075_ifu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] raddr, inst, inst_pc;
    logic [31:0] rdata = '0;
    logic [31:0] pc_next = '0;
    logic        rvalid, out_valid, err;
    logic        rready = 1'b0;
    logic        out_ready = 1'b0;
    logic        pc_valid = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc = 32'h8000_0000;

    always #5 clk = ~clk;

    ysyx_23060075_ifu dut (
        .clk(clk), .rst(rst), .raddr_o(raddr), .rvalid_o(rvalid), .rdata_i(rdata),
        .rready_i(rready), .inst_o(inst), .inst_pc_o(inst_pc), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .pc_valid_i(pc_valid), .pc_next_i(pc_next), .err_o(err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : ((a * 32'h9E37_79B9) ^ 32'h5A5A_A5A5);
    endfunction

    task automatic test_reset(input int cycles);
        rst = 1'b1; rready = 1'b0; out_ready = 1'b0; pc_valid = 1'b0;
        repeat (cycles) step;
        checks++; if (raddr !== 32'h8000_0000) begin errors++; $display("FAIL reset_raddr got=%h exp=80000000", raddr); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
        model_pc = 32'h8000_0000;
    endtask

    task automatic do_fetch(input int lat, input bit pre_ready, input bit noise);
        int n = 0;
        while (rvalid !== 1'b1 && n < 20) begin step; n++; end
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL req_seen got=%b exp=1", rvalid); end
        checks++; if (raddr !== model_pc) begin errors++; $display("FAIL req_addr got=%h exp=%h", raddr, model_pc); end
        if (pre_ready) out_ready = 1'b1;
        step;
        for (int i = 1; i < lat; i++) begin
            checks++;
            if (rvalid !== 1'b0 || out_valid !== 1'b0 || raddr !== model_pc) begin
                errors++; $display("FAIL wait_stable got=%b/%b/%h exp=0/0/%h", rvalid, out_valid, raddr, model_pc);
            end
            if (noise) begin pc_valid = 1'b1; pc_next = $urandom; end
            step;
        end
        pc_valid = 1'b0;
        rready = 1'b1; rdata = mem(raddr);
        step;
        rready = 1'b0; rdata = $urandom;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cap_valid got=%b exp=1", out_valid); end
        checks++; if (inst !== mem(model_pc)) begin errors++; $display("FAIL cap_inst got=%h exp=%h", inst, mem(model_pc)); end
        checks++; if (inst_pc !== model_pc) begin errors++; $display("FAIL cap_pc got=%h exp=%h", inst_pc, model_pc); end
    endtask

    task automatic handshake(input int d, input bit pre_ready);
        if (!pre_ready) begin
            repeat (d) begin
                rready = 1'b1; rdata = 32'hDEAD_BEEF; pc_valid = 1'b1; pc_next = $urandom;
                step;
                checks++;
                if (out_valid !== 1'b1 || rvalid !== 1'b0 || inst !== mem(model_pc) || inst_pc !== model_pc) begin
                    errors++; $display("FAIL hold_stable got=%b/%b/%h/%h exp=1/0/%h/%h", out_valid, rvalid, inst, inst_pc, mem(model_pc), model_pc);
                end
            end
            rready = 1'b0; pc_valid = 1'b0;
            out_ready = 1'b1;
        end
        step;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hs_drop got=%b exp=0", out_valid); end
    endtask

    task automatic go_next(input int d, input logic [31:0] a);
        repeat (d) begin
            step;
            checks++; if (rvalid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL next_idle got=%b/%b exp=0/0", rvalid, out_valid); end
        end
        pc_valid = 1'b1; pc_next = a;
        step;
        pc_valid = 1'b0; pc_next = $urandom;
        model_pc = a;
    endtask

    task automatic test_first_fetch_and_stall;
        test_reset(2);
        do_fetch(2, 1'b0, 1'b0);
        handshake(20, 1'b0);
    endtask

    task automatic test_next_pc;
        go_next(0, 32'h8000_0010);
        do_fetch(5, 1'b0, 1'b1);
        handshake(1, 1'b0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            bit pre;
            pre = 1'($urandom);
            go_next($urandom_range(0, 3), $urandom);
            do_fetch($urandom_range(2, 11), pre, 1'($urandom));
            handshake($urandom_range(0, 4), pre);
        end
    endtask

    task automatic test_reset_mid_wait;
        int n = 0;
        go_next(1, 32'h8000_0010);
        while (rvalid !== 1'b1 && n < 20) begin step; n++; end
        repeat (3) step;
        test_reset(1);
        do_fetch(3, 1'b0, 1'b0);
        handshake(0, 1'b0);
    endtask

    task automatic test_timeout;
        int n = 0;
        test_reset(1);
        while (rvalid !== 1'b1 && n < 20) begin step; n++; end
`ifdef YSYX_23060075_IFU_TIMEOUT_EN
        repeat (1023) step;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_early got=%b exp=0", err); end
        step;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", err); end
        repeat (30) begin
            rready = 1'b1; rdata = 32'hDEAD_BEEF;
            step;
            checks++; if (rvalid !== 1'b0 || out_valid !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL to_halt got=%b/%b/%b exp=0/0/1", rvalid, out_valid, err); end
        end
        rready = 1'b0;
`else
        repeat (1100) begin
            step;
            checks++; if (rvalid !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL no_to got=%b/%b/%b exp=0/0/0", rvalid, out_valid, err); end
        end
        rready = 1'b1; rdata = mem(raddr);
        step;
        rready = 1'b0;
        checks++; if (out_valid !== 1'b1 || inst !== mem(model_pc)) begin errors++; $display("FAIL late_cap got=%b/%h exp=1/%h", out_valid, inst, mem(model_pc)); end
`endif
        test_reset(1);
    endtask

    initial begin
        test_first_fetch_and_stall;
        test_next_pc;
        test_random;
        test_reset_mid_wait;
        test_timeout;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
